// File: rtl/rsp_arb.sv
// Round-robin merge of the adc/flash/ctrl response streams onto one response bus.
// Packets are forwarded one cycle late, followed by a forced idle gap and a per-grant timeout.
module rsp_arb #(
    parameter int P_GAP     = 2,
    parameter int P_TIMEOUT = 1024
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_adc_req,
    output logic       o_adc_grant,
    input  logic [7:0] i_adc_len,
    input  logic [7:0] i_adc_data,
    input  logic       i_adc_last,
    input  logic       i_adc_valid,
    input  logic       i_flash_req,
    output logic       o_flash_grant,
    input  logic [7:0] i_flash_len,
    input  logic [7:0] i_flash_data,
    input  logic       i_flash_last,
    input  logic       i_flash_valid,
    input  logic       i_ctrl_req,
    output logic       o_ctrl_grant,
    input  logic [7:0] i_ctrl_len,
    input  logic [7:0] i_ctrl_data,
    input  logic       i_ctrl_last,
    input  logic       i_ctrl_valid,
    output logic [7:0] o_rsp_len,
    output logic [7:0] o_rsp_data,
    output logic       o_rsp_last,
    output logic       o_rsp_valid,
    output logic       o_timeout
);
    // state | meaning
    // IDLE  | sample requests, pick the next source round-robin
    // GRANT | grant held, waiting for the first byte
    // XFER  | streaming the granted packet
    // GAP   | forced idle between packets, all grants low
    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_XFER, S_GAP} state_t;

    localparam int TW = $clog2(P_TIMEOUT + 1);
    localparam int GW = $clog2(P_GAP + 1);

    state_t          r_state;
    logic [1:0]      r_ptr;
    logic [1:0]      r_gidx;
    logic [2:0]      r_grant;
    logic [7:0]      r_len;
    logic [7:0]      r_data;
    logic            r_last;
    logic            r_valid;
    logic            r_timeout;
    logic [TW-1:0]   r_tmo_cnt;
    logic [GW-1:0]   r_gap_cnt;

    logic [2:0]      w_req;
    logic [1:0]      w_c0, w_c1, w_c2, w_sel;
    logic            w_g_valid, w_g_last;
    logic [7:0]      w_g_len, w_g_data;

    function automatic logic [1:0] f_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign w_req = {i_ctrl_req, i_flash_req, i_adc_req};
    assign w_c0  = r_ptr;
    assign w_c1  = f_next(w_c0);
    assign w_c2  = f_next(w_c1);

    always_comb begin
        w_sel = w_c2;
        if (w_req[w_c0])      w_sel = w_c0;
        else if (w_req[w_c1]) w_sel = w_c1;
    end

    // Only the granted source's inputs ever reach the output registers.
    always_comb begin
        w_g_valid = 1'b0;
        w_g_last  = 1'b0;
        w_g_len   = 8'h00;
        w_g_data  = 8'h00;
        case (r_gidx)
            2'd0: begin
                w_g_valid = i_adc_valid;   w_g_last = i_adc_last;
                w_g_len   = i_adc_len;     w_g_data = i_adc_data;
            end
            2'd1: begin
                w_g_valid = i_flash_valid; w_g_last = i_flash_last;
                w_g_len   = i_flash_len;   w_g_data = i_flash_data;
            end
            2'd2: begin
                w_g_valid = i_ctrl_valid;  w_g_last = i_ctrl_last;
                w_g_len   = i_ctrl_len;    w_g_data = i_ctrl_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_ptr     <= 2'd0;
            r_gidx    <= 2'd0;
            r_grant   <= 3'b000;
            r_len     <= 8'h00;
            r_data    <= 8'h00;
            r_last    <= 1'b0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_tmo_cnt <= '0;
            r_gap_cnt <= '0;
        end else begin
            r_timeout <= 1'b0;
            r_len     <= 8'h00;
            r_data    <= 8'h00;
            r_last    <= 1'b0;
            r_valid   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|w_req) begin
                        r_gidx    <= w_sel;
                        r_grant   <= 3'b001 << w_sel;
                        r_tmo_cnt <= TW'(P_TIMEOUT - 1);
                        r_state   <= S_GRANT;
                    end
                end
                S_GRANT, S_XFER: begin
                    if (w_g_valid) begin
                        r_valid   <= 1'b1;
                        r_len     <= w_g_len;
                        r_data    <= w_g_data;
                        r_last    <= w_g_last;
                        r_tmo_cnt <= TW'(P_TIMEOUT - 1);
                        r_state   <= S_XFER;
                        if (w_g_last) begin
                            r_grant   <= 3'b000;
                            r_ptr     <= f_next(r_gidx);
                            r_gap_cnt <= GW'(P_GAP - 1);
                            r_state   <= S_GAP;
                        end
                    end else if (r_tmo_cnt == '0) begin
                        // A valid byte at terminal count wins; only a silent source times out.
                        r_timeout <= 1'b1;
                        r_grant   <= 3'b000;
                        r_ptr     <= f_next(r_gidx);
                        r_gap_cnt <= GW'(P_GAP - 1);
                        r_state   <= S_GAP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt - 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == '0) r_state   <= S_IDLE;
                    else                 r_gap_cnt <= r_gap_cnt - 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_adc_grant   = r_grant[0];
    assign o_flash_grant = r_grant[1];
    assign o_ctrl_grant  = r_grant[2];
    assign o_rsp_len     = r_len;
    assign o_rsp_data    = r_data;
    assign o_rsp_last    = r_last;
    assign o_rsp_valid   = r_valid;
    assign o_timeout     = r_timeout;

endmodule
